// File: rtl/enemy_scan_scheduler.sv
// rtl/enemy_scan_scheduler.sv - time-multiplexed enemy hit scan with blood, respawn and kill score
module enemy_scan_scheduler #(
    parameter int         ENEMY_NUM    = 4,
    parameter int         RESPAWN_TIME = 200,
    parameter int         PRESCALE     = 4,
    parameter logic [6:0] MAX_BLOOD    = 7'd100,
    parameter logic [6:0] DAMAGE       = 7'd100
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic                   Attack_On,
    input  logic [9*ENEMY_NUM-1:0] Enemy_X_All,
    input  logic [9*ENEMY_NUM-1:0] Enemy_Y_All,
    output logic [8:0]             Hit_X,
    output logic [8:0]             Hit_Y,
    output logic                   Hit_Req,
    input  logic                   Hit_In,
    output logic [ENEMY_NUM-1:0]   Enemy_Alive,
    output logic [7:0]             Score,
    output logic                   Busy
);

    localparam int IW = (ENEMY_NUM > 1) ? $clog2(ENEMY_NUM) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;

    localparam logic [IW-1:0] LAST_IDX   = IW'(ENEMY_NUM - 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [9:0]    TIMER_LAST = 10'(RESPAWN_TIME - 1);

    logic          frame_d;
    logic          tick;
    logic          step;
    logic [PW-1:0] presc;
    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          atk;
    logic          stp;
    logic [7:0]    score_q;
    logic [6:0]    blood [ENEMY_NUM];
    logic [9:0]    timer [ENEMY_NUM];

    logic [6:0]    cur_blood;
    logic [9:0]    cur_timer;
    logic          cur_alive;
    logic          hit_now;
    logic [6:0]    dmg_blood;

    // The prescaler sees every frame tick, even those dropped because a scan is running.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_d <= 1'b0;
            tick    <= 1'b0;
            presc   <= '0;
        end else begin
            frame_d <= frame_clk;
            tick    <= frame_clk & ~frame_d;
            if (tick) begin
                presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
            end
        end
    end

    assign step = tick && (presc == PRE_LAST);

    always_comb begin
        cur_blood = '0;
        cur_timer = '0;
        Hit_X     = '0;
        Hit_Y     = '0;
        for (int i = 0; i < ENEMY_NUM; i++) begin
            if (idx == IW'(i)) begin
                cur_blood = blood[i];
                cur_timer = timer[i];
                Hit_X     = Enemy_X_All[9*i +: 9];
                Hit_Y     = Enemy_Y_All[9*i +: 9];
            end
        end
    end

    assign cur_alive = (cur_blood != 7'd0);
    assign hit_now   = cur_alive && atk && Hit_In;
    assign dmg_blood = (cur_blood > DAMAGE) ? cur_blood - DAMAGE : 7'd0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            atk     <= 1'b0;
            stp     <= 1'b0;
            score_q <= '0;
            for (int i = 0; i < ENEMY_NUM; i++) begin
                blood[i] <= MAX_BLOOD;
                timer[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        atk   <= Attack_On;
                        stp   <= step;
                        idx   <= '0;
                        state <= S_PRESENT;
                    end
                end
                S_PRESENT: state <= S_CHECK;
                S_CHECK: begin
                    // A kill takes priority, so a freshly killed slot never ages its timer in the same scan.
                    if (hit_now) begin
                        blood[idx] <= dmg_blood;
                        if (dmg_blood == 7'd0 && score_q != 8'hFF) begin
                            score_q <= score_q + 8'd1;
                        end
                    end else if (!cur_alive && stp) begin
                        if (cur_timer == TIMER_LAST) begin
                            timer[idx] <= '0;
                            blood[idx] <= MAX_BLOOD;
                        end else begin
                            timer[idx] <= cur_timer + 10'd1;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= S_IDLE;
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= S_PRESENT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Enemy_Alive = '0;
        for (int i = 0; i < ENEMY_NUM; i++) begin
            Enemy_Alive[i] = (blood[i] != 7'd0);
        end
    end

    assign Hit_Req = (state == S_PRESENT);
    assign Busy    = (state != S_IDLE);
    assign Score   = score_q;

endmodule

// File: doc/enemy_scan_scheduler.md
# enemy_scan_scheduler

Time-multiplexes one shared attack hit comparator across `ENEMY_NUM` enemy slots. On each frame tick it sequences every slot through the comparator in turn and applies damage to the slot it tests. It also keeps each slot's blood, alive flag and respawn timer, and maintains the kill score. It sits between the enemy movement logic (slot coordinates) and the attack hit comparator, and it drives the per-enemy alive flags used by sprite drawing.

## Interface
Parameters:
- `ENEMY_NUM`, 4, number of enemy slots.
- `RESPAWN_TIME`, 200, respawn steps a dead slot waits before revival.
- `PRESCALE`, 4, frame ticks per respawn step.
- `MAX_BLOOD`, 100, blood on reset and on respawn (7-bit).
- `DAMAGE`, 100, blood removed per registered hit (7-bit).

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `frame_clk`  in  1  raw frame clock. Its rising edges are detected internally.
- `Attack_On`  in  1  player attack active.
- `Enemy_X_All`  in  9*ENEMY_NUM  packed slot X coordinates; slot i occupies [9i+8:9i].
- `Enemy_Y_All`  in  9*ENEMY_NUM  packed slot Y coordinates, same packing.
- `Hit_X`, `Hit_Y`  out  9  coordinates of the slot currently selected for the comparator.
- `Hit_Req`  out  1  high while a slot's coordinates are being presented.
- `Hit_In`  in  1  comparator result, registered. It is valid the cycle after `Hit_Req`.
- `Enemy_Alive`  out  ENEMY_NUM  bit i = (blood[i] != 0).
- `Score`  out  8  kill count.
- `Busy`  out  1  a scan is in progress.

## Operation
- Frame edge detection: `frame_clk` is registered into a delay flop. A one-cycle pulse `tick` is registered as (frame_clk & ~delayed).
- Prescaler: a 2-bit counter (width = clog2(PRESCALE)) advances on every `tick`, including ticks that arrive during a scan. It wraps at PRESCALE-1, and the wrapping tick sets `step`.
- State machine: IDLE -> PRESENT -> CHECK -> (PRESENT with idx+1 | IDLE).
  - IDLE, on `tick`: latch `atk` = `Attack_On`, latch `stp` = `step`, set idx = 0, go to PRESENT. A `tick` outside IDLE starts no scan (it is dropped).
  - PRESENT: `Hit_Req` = 1; go to CHECK.
  - CHECK: sample `Hit_In` and update slot idx. If idx = ENEMY_NUM-1, go to IDLE; otherwise idx+1 and go to PRESENT.
- `Hit_X`/`Hit_Y` are a combinational mux of slot idx. idx holds its value in IDLE, so the comparator sees stable inputs.
- Slot update in CHECK, evaluated on pre-update values:
  - If alive & `atk` & `Hit_In`:
    - blood = blood - DAMAGE, saturating at 0.
    - If the result is 0, the slot dies and `Score` increments, saturating at 255.
    - Score counts kills, not hits.
  - Else if dead & `stp`:
    - If timer = RESPAWN_TIME-1: timer = 0 and blood = MAX_BLOOD (the slot revives).
    - Otherwise timer + 1.
  - A slot killed in this scan does not advance its timer in the same scan.
- Timer width is 10 bits; RESPAWN_TIME ≤ 1023.
- `Busy` = (state != IDLE).

## Timing
- Reset values: every blood = MAX_BLOOD, `Enemy_Alive` all ones, timers 0, `Score` 0, idx 0, state IDLE, `Hit_Req` 0, `Busy` 0, prescaler 0, delay flop 0, `tick` 0.
- Scan latency, with `tick` high in cycle E:
  - PRESENT slot k occurs at E+1+2k; CHECK slot k at E+2+2k.
  - Slot k's blood, alive and timer update is visible at E+3+2k.
  - State is back in IDLE at E+1+2·ENEMY_NUM (E+9 for 4 slots).
  - Frame period must exceed 2·ENEMY_NUM+1 cycles.
- `Attack_On` changes during a scan are ignored; the value latched at `tick` applies to the whole scan.
- `Hit_In` is ignored outside CHECK.
- Reset asserted mid-scan: the next cycle is the full reset state. A partial scan leaves no residual update.
- Two slots with identical coordinates are tested independently; both can be damaged in one scan.

## Test plan
- Reset: hold `Reset` 2 cycles, then release -> `Enemy_Alive`=4'b1111, `Score`=0, `Busy`=0, `Hit_Req`=0.
- Single kill: `Attack_On`=1, bench returns `Hit_In`=1 only for slot 2 (X=100,Y=60), one tick -> `Hit_Req` pulses 4 times with `Hit_X`=100 on the third, `Enemy_Alive`=4'b1011 at E+7, `Score`=1, `Busy` low at E+9.
- Partial damage, DAMAGE=40: slot 0 hit on 3 consecutive scans -> blood 60, 20, 0; alive drops only after the third scan; `Score` increments once.
- No attack: `Attack_On`=0 with `Hit_In` forced to 1 -> no blood change, `Score` stays 0.
- Respawn: kill slot 1, then keep `Attack_On`=0 -> slot 1 revives with blood 100 after exactly 200 steps = 800 ticks (PRESCALE=4). Check alive is still 0 at tick 799.
- Robustness:
  - A `tick` during `Busy` starts no new scan, but the prescaler still counts it.
  - `Reset` at E+4 returns all outputs to reset values at E+5.
  - 256 kills leave `Score`=255.
